mult_scheduler: RTL and testbench
=================================

MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1  lane 0 / lane 1 Execute-stage multiply request; held until granted.
REQ-005 signed0, signed1  input  1  1 = signed mult, 0 = unsigned multu, per lane.
REQ-006 a0, b0, a1, b1  input  WIDTH  per-lane operands, valid while the matching req is high.
REQ-007 gnt0, gnt1  output  1  combinational acceptance of the lane request this cycle; never both high.
REQ-008 start_mult  output  1  equals gnt0 | gnt1; drives the hazard unit start_multE input.
REQ-009 busy_mult  output  1  high in RUN and FIX; drives the hazard unit busy_multE input.
REQ-010 done  output  1  one-cycle pulse in the FIX cycle.
REQ-011 hi, lo  output  WIDTH  registered upper and lower product halves.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-013 IDLE: a grant SHALL occur only in IDLE; if any req is high, the block grants one lane, latches that lane's operands and signedness, clears the iteration count, and moves to RUN.
REQ-014 Arbitration SHALL be round-robin.
- A single requester wins.
- When both lanes request, the lane not granted last wins.
- The last-granted pointer updates only on a grant.
REQ-015 Operand latch SHALL be as follows.
- Signed: store |a| and |b| and neg = a[msb] ^ b[msb].
- Unsigned: store a and b unchanged and neg = 0.
- |most-negative| is taken as the unsigned value 2^(WIDTH-1).
REQ-016 RUN SHALL perform one radix-2 shift-add iteration per cycle on a 2*WIDTH accumulator.
- If the multiplier LSB is 1, add the multiplicand to the upper half with carry retained.
- Shift the accumulator and multiplier right by 1.
- Increment the count.
REQ-017 RUN SHALL last exactly WIDTH cycles, after which the FSM moves to FIX.
REQ-018 FIX SHALL load the accumulator into {hi,lo}, two's-complement negated over 2*WIDTH bits if neg = 1, assert done, and return to IDLE.
REQ-019 Latency SHALL be as follows.
- Grant in cycle T.
- done in cycle T+WIDTH+1.
- New hi/lo visible from cycle T+WIDTH+2.
- The earliest next grant is in cycle T+WIDTH+2.
REQ-020 Requests arriving in RUN or FIX SHALL NOT be granted (gnt = 0); the requester holds req and the hazard unit stalls on busy_mult.
REQ-021 Operand or req changes after the grant cycle SHALL NOT affect the operation in progress.
REQ-022 hi and lo SHALL hold their value except in the FIX cycle.
REQ-023 done, gnt0, gnt1 and start_mult SHALL be 0 whenever the state is not IDLE, with the one exception that done is 1 in FIX.
REQ-024 All arithmetic SHALL be modulo 2^(2*WIDTH); there is no overflow flag.

Reset
REQ-025 When reset = 0, the block SHALL immediately, without waiting for clk, enter IDLE with:
- count = 0;
- last-granted pointer = lane 1, so lane 0 wins the first tie;
- hi = 0 and lo = 0;
- busy_mult = 0;
- done = 0.
REQ-026 Reset asserted during RUN or FIX SHALL abort the operation; no done pulse and no hi/lo update occur.
REQ-027 On the first clk edge after reset deasserts, a pending req SHALL be grantable.

Verification
REQ-028 Unsigned single lane: req0 with a0 = 3, b0 = 5, signed0 = 0 at T.
- Response: gnt0 = 1 and start_mult = 1 at T.
- busy_mult = 1 for T+1..T+33.
- done at T+33.
- hi = 0x00000000, lo = 0x0000000F at T+34.
REQ-029 Signed: a = 0xFFFFFFFE (-2), b = 3, signed = 1 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
REQ-030 Unsigned max: a = b = 0xFFFFFFFF, signed = 0 -> hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-031 Signed most-negative: a = b = 0x80000000, signed = 1 -> hi = 0x40000000, lo = 0x00000000.
REQ-032 Contention after reset: req0 and req1 both high and held.
- Lane 0 is granted first.
- Lane 1 is granted at the IDLE cycle after done.
- gnt is never asserted during busy_mult.
- On a third tie, lane 0 wins.
REQ-033 Reset abort: pull reset low at T+10 of an operation.
- Response: busy_mult = 0 immediately.
- No done pulse.
- hi = lo = 0.
- A held req0 is granted on the first edge after release.

Source files
------------

// File: rtl/mult_scheduler.sv
// rtl/mult_scheduler.sv - two-lane round-robin scheduler for an iterative shift-add multiplier
module mult_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             signed0,
  input  logic             signed1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             start_mult,
  output logic             busy_mult,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  state_t             state_nx;
  logic [CW-1:0]      count;
  logic               last_gnt;     // 1 = lane 1 was granted most recently
  logic               neg;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;          // upper half: partial sum, lower half: remaining multiplier bits

  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic               s_sel;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod;

  // Next-state, round-robin grant and status outputs
  always_comb begin
    state_nx  = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    busy_mult = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        gnt0 = req0 & (~req1 | last_gnt);
        gnt1 = req1 & (~req0 | ~last_gnt);
        if (gnt0 | gnt1) state_nx = RUN;
      end
      RUN: begin
        busy_mult = 1'b1;
        if (count == CW'(WIDTH - 1)) state_nx = FIX;
      end
      FIX: begin
        busy_mult = 1'b1;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign start_mult = gnt0 | gnt1;

  // Operand selection and magnitude conversion; the most-negative value maps to 2^(WIDTH-1)
  always_comb begin
    a_sel = gnt1 ? a1 : a0;
    b_sel = gnt1 ? b1 : b0;
    s_sel = gnt1 ? signed1 : signed0;
    a_abs = (s_sel & a_sel[WIDTH-1]) ? -a_sel : a_sel;
    b_abs = (s_sel & b_sel[WIDTH-1]) ? -b_sel : b_sel;
  end

  // One shift-add step: conditional add into the upper half keeping the carry, then shift right
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    acc_nx = {sum, acc[WIDTH-1:1]};
    prod   = neg ? -acc : acc;
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      last_gnt <= 1'b1;
      neg      <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            last_gnt <= gnt1;
            mcand    <= a_abs;
            acc      <= {{WIDTH{1'b0}}, b_abs};
            neg      <= s_sel & (a_sel[WIDTH-1] ^ b_sel[WIDTH-1]);
            count    <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          count <= count + CW'(1);
        end
        FIX: begin
          {hi, lo} <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// tb/tb_mult_scheduler.sv - directed vector bench for mult_scheduler
module tb_mult_scheduler;

  logic        clk;
  logic        reset;
  logic        req0, req1, signed0, signed1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, start_mult, busy_mult, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_hi, prev_lo;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl[10];

  mult_scheduler #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .signed0(signed0), .signed1(signed1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .start_mult(start_mult),
    .busy_mult(busy_mult), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_op(input int lane, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    if (lane == 0) begin req0 = 1'b1; signed0 = sgn; a0 = a; b0 = b; end
    else           begin req1 = 1'b1; signed1 = sgn; a1 = a; b1 = b; end
    #1;
    chk("grant", {gnt1, gnt0}, (lane == 0) ? 64'd1 : 64'd2);
    chk("start_mult", start_mult, 1);
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    signed0 = ~signed0; signed1 = ~signed1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      chk("busy", busy_mult, 1);
      chk("done_timing", done, (c == 33));
      chk("no_grant_busy", {gnt1, gnt0, start_mult}, 0);
      chk("hold_hilo", {hi, lo}, {prev_hi, prev_lo});
      if (c == 33) begin req0 = 1'b0; req1 = 1'b0; end
    end
    @(negedge clk);
    chk("busy_end", busy_mult, 0);
    chk("result", {hi, lo}, {ehi, elo});
    prev_hi = ehi; prev_lo = elo;
  endtask

  initial begin
    logic [1:0]  exp_lane [3];
    logic [63:0] exp_res  [2];

    tbl[0] = '{1'b0, 32'd3,          32'd5,          32'h00000000, 32'h0000000F};
    tbl[1] = '{1'b1, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[2] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    tbl[3] = '{1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
    tbl[4] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001};
    tbl[5] = '{1'b1, 32'd7,          32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFF9};
    tbl[6] = '{1'b0, 32'h80000000,   32'd2,          32'h00000001, 32'h00000000};
    tbl[7] = '{1'b1, 32'd0,          32'hFFFFFFFB,   32'h00000000, 32'h00000000};
    tbl[8] = '{1'b0, 32'h12345678,   32'h00000010,   32'h00000001, 32'h23456780};
    tbl[9] = '{1'b1, 32'h80000000,   32'd1,          32'hFFFFFFFF, 32'h80000000};

    reset = 1'b1;
    req0 = 0; req1 = 0; signed0 = 0; signed1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    prev_hi = 0; prev_lo = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy_mult, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_gnt", {gnt1, gnt0, start_mult}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op(i % 2, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo);

    // Contention after reset: lane 0, lane 1, lane 0
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req0 = 1; signed0 = 0; a0 = 32'h00010001; b0 = 32'h00010000;
    req1 = 1; signed1 = 1; a1 = 32'hFFFFFFFD; b1 = 32'd4;
    exp_lane[0] = 2'b01; exp_lane[1] = 2'b10; exp_lane[2] = 2'b01;
    exp_res[0] = 64'h00000001_00010000;
    exp_res[1] = 64'hFFFFFFFF_FFFFFFF4;
    #1;
    chk("tie0_grant", {gnt1, gnt0}, exp_lane[0]);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
      end
      for (int c = 1; c <= 33; c++) begin
        @(negedge clk);
        chk("tie_no_grant", {gnt1, gnt0, start_mult}, 0);
        chk("tie_busy", busy_mult, 1);
        chk("tie_done", done, (c == 33));
      end
      @(negedge clk); #1;
      chk("tie_result", {hi, lo}, exp_res[k % 2]);
      if (k < 2) chk("tie_grant", {gnt1, gnt0}, exp_lane[k + 1]);
      else       chk("tie_idle", {gnt1, gnt0, busy_mult}, 0);
    end

    // Reset abort at T+10 with a held request
    req0 = 1; signed0 = 0; a0 = 32'd9; b0 = 32'd9;
    #1;
    chk("abort_grant", gnt0, 1);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    chk("abort_pre_busy", busy_mult, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy_mult, 0);
    chk("abort_done", done, 0);
    chk("abort_hilo", {hi, lo}, 0);
    @(negedge clk);
    chk("abort_hold_busy", busy_mult, 0);
    chk("abort_hold_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("release_grant", {gnt1, gnt0}, 2'b01);
    @(posedge clk); #1;
    req0 = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      chk("release_done", done, (c == 33));
    end
    @(negedge clk);
    chk("release_result", {hi, lo}, 64'd81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
